// File: rtl/pipelined_mult_array_if.sv
// pipelined_mult_array_if
// Bundles the lane-set handshake and data buses of pipelined_mult_array.
//   in_valid / in_ready     : input lane-set handshake
//   lane_en    [N]          : per-lane enable, sampled with the input set
//   weights    [N*DW]       : signed lane weights, lane i at [i*DW +: DW]
//   pixel_data [N*DW]       : signed lane pixels, same packing
//   out_valid / out_ready   : result handshake
//   result     [N*DW]       : scaled lane products, same packing
//   ovf        [N]          : per-lane overflow flags aligned with result
// master drives a lane set and accepts results; slave is the multiplier.
interface pipelined_mult_array_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3
);
    localparam int N = KERNEL_SIZE * KERNEL_SIZE;

    logic                    in_valid;
    logic                    in_ready;
    logic [N-1:0]            lane_en;
    logic [N*DATA_WIDTH-1:0] weights;
    logic [N*DATA_WIDTH-1:0] pixel_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [N*DATA_WIDTH-1:0] result;
    logic [N-1:0]            ovf;

    modport master (
        output in_valid, lane_en, weights, pixel_data, out_ready,
        input  in_ready, out_valid, result, ovf
    );

    modport slave (
        input  in_valid, lane_en, weights, pixel_data, out_ready,
        output in_ready, out_valid, result, ovf
    );
endinterface

// File: rtl/pipelined_mult_array.sv
// pipelined_mult_array
// Multiplies KERNEL_SIZE^2 signed weight/pixel lanes in parallel, rescales each
// full-width product by FRAC_BITS with round-half-up, flags per-lane overflow
// and carries the sets through a PIPE_STAGES-deep valid/ready pipeline.
// Ports:
//   clk   : clock, everything on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : pipelined_mult_array_if.slave (handshakes, lane data, results)
// Optional feature macro: MULT_SATURATE_EN
//   defined   -> overflowing lanes clamp to the signed DATA_WIDTH limits
//   undefined -> overflowing lanes keep the low DATA_WIDTH bits (wrap)
// in_ready is combinational from out_ready: the whole pipe advances together.
module pipelined_mult_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int FRAC_BITS   = 0,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_mult_array_if.slave bus
);
    localparam int N      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PW     = 2 * DATA_WIDTH;
    localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    // Half an LSB of the rescaled value; zero when there is no fraction.
    localparam logic signed [PW:0] RND_ADD =
        (FRAC_BITS > 0) ? ({{PW{1'b0}}, 1'b1} <<< RND_SH) : '0;
    localparam logic signed [PW:0] MAX_V = {{(PW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW:0] MIN_V = {{(PW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic                    advance_s;
    logic                    out_valid_r;
    logic [N*DATA_WIDTH-1:0] result_r;
    logic [N-1:0]            ovf_r;
    logic [N*PW-1:0]         prod_s;
    logic signed [PW-1:0]    w_ext_s;
    logic signed [PW-1:0]    x_ext_s;
    logic [N*PW-1:0]         tail_prod_s;
    logic [N-1:0]            tail_en_s;
    logic                    tail_valid_s;
    logic [N*DATA_WIDTH-1:0] next_result_s;
    logic [N-1:0]            next_ovf_s;
    logic signed [PW:0]      ext_s;
    logic signed [PW:0]      scaled_s;
    logic                    lane_ovf_s;

    assign advance_s     = !out_valid_r || bus.out_ready;
    assign bus.in_ready  = advance_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.ovf       = ovf_r;

    // Stage-1 multipliers: sign-extend both operands to full product width.
    always_comb begin
        prod_s  = '0;
        w_ext_s = '0;
        x_ext_s = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.lane_en[i]) begin
                w_ext_s = {{DATA_WIDTH{bus.weights[i*DATA_WIDTH+DATA_WIDTH-1]}},
                           bus.weights[i*DATA_WIDTH +: DATA_WIDTH]};
                x_ext_s = {{DATA_WIDTH{bus.pixel_data[i*DATA_WIDTH+DATA_WIDTH-1]}},
                           bus.pixel_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end else begin
                // Gated operands keep disabled lanes from toggling the multiplier.
                w_ext_s = '0;
                x_ext_s = '0;
            end
            prod_s[i*PW +: PW] = w_ext_s * x_ext_s;
        end
    end

    generate
        if (PIPE_STAGES > 1) begin : g_delay
            localparam int D = PIPE_STAGES - 1;
            logic [N*PW-1:0] prod_r [D];
            logic [N-1:0]    en_r   [D];
            logic [D-1:0]    valid_r;

            // Product register and any pure delay stages ahead of the output stage.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_r <= '0;
                    for (int s = 0; s < D; s++) begin
                        prod_r[s] <= '0;
                        en_r[s]   <= '0;
                    end
                end else if (advance_s) begin
                    valid_r[0] <= bus.in_valid;
                    prod_r[0]  <= prod_s;
                    en_r[0]    <= bus.lane_en;
                    for (int s = 1; s < D; s++) begin
                        valid_r[s] <= valid_r[s-1];
                        prod_r[s]  <= prod_r[s-1];
                        en_r[s]    <= en_r[s-1];
                    end
                end
            end

            assign tail_prod_s  = prod_r[D-1];
            assign tail_en_s    = en_r[D-1];
            assign tail_valid_s = valid_r[D-1];
        end else begin : g_direct
            // Single stage: multiply and rescale land in the same register.
            assign tail_prod_s  = prod_s;
            assign tail_en_s    = bus.lane_en;
            assign tail_valid_s = bus.in_valid;
        end
    endgenerate

    // Output-stage rescale: one extra bit keeps the rounding add from wrapping.
    always_comb begin
        next_result_s = '0;
        next_ovf_s    = '0;
        ext_s         = '0;
        scaled_s      = '0;
        lane_ovf_s    = 1'b0;
        for (int i = 0; i < N; i++) begin
            ext_s      = signed'({tail_prod_s[i*PW+PW-1], tail_prod_s[i*PW +: PW]}) + RND_ADD;
            scaled_s   = ext_s >>> FRAC_BITS;
            lane_ovf_s = (scaled_s > MAX_V) || (scaled_s < MIN_V);
            if (!tail_en_s[i]) begin
                next_result_s[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                next_ovf_s[i] = 1'b0;
            end else begin
                next_ovf_s[i] = lane_ovf_s;
`ifdef MULT_SATURATE_EN
                if (lane_ovf_s) begin
                    next_result_s[i*DATA_WIDTH +: DATA_WIDTH] =
                        scaled_s[PW] ? MIN_V[DATA_WIDTH-1:0] : MAX_V[DATA_WIDTH-1:0];
                end else begin
                    next_result_s[i*DATA_WIDTH +: DATA_WIDTH] = scaled_s[DATA_WIDTH-1:0];
                end
`else
                next_result_s[i*DATA_WIDTH +: DATA_WIDTH] = scaled_s[DATA_WIDTH-1:0];
`endif
            end
        end
    end

    // Output register: holds while stalled, bubbles are dropped here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= '0;
            ovf_r       <= '0;
        end else if (advance_s) begin
            out_valid_r <= tail_valid_s;
            result_r    <= next_result_s;
            ovf_r       <= next_ovf_s;
        end
    end
endmodule
